// File: rtl/nios_processor_adc_pkg.sv
// nios_processor_adc_pkg: register map, bit indices and FSM states shared by the ADC sequencer
package nios_processor_adc_pkg;
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DIV    = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_DATA   = 2'd3;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_CLR     = 1;
  localparam int CTRL_THR_LSB = 8;
  localparam int STAT_OVF     = 16;
  localparam int STAT_OVR     = 17;
  localparam int STAT_BUSY    = 18;
  localparam int DIV_MIN      = 4;
  typedef enum logic [1:0] {IDLE, START, CONV, CAPT} adc_state_e;
endpackage

// File: rtl/nios_processor_adc_fifo.sv
// nios_processor_adc_fifo: synchronous sample FIFO with flush, level and full/empty flags
module nios_processor_adc_fifo #(
  parameter int DATA_W  = 16,
  parameter int FIFO_AW = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [FIFO_AW:0]  level,
  output logic              full,
  output logic              empty
);
  localparam int DEPTH = 1 << FIFO_AW;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0] level_q, level_d;
  logic do_push, do_pop;
  assign full  = level_q == (FIFO_AW+1)'(DEPTH);
  assign empty = level_q == '0;
  assign level = level_q;
  assign rdata = mem[rd_ptr_q];
  // a push into a full FIFO only lands when a pop frees the slot in the same cycle; flush beats both
  always_comb begin
    do_push  = push & (~full | pop) & ~flush;
    do_pop   = pop & ~empty & ~flush;
    wr_ptr_d = flush ? '0 : wr_ptr_q + FIFO_AW'(do_push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + FIFO_AW'(do_pop);
    level_d  = flush ? '0 : level_q + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
  end
  // sample storage, no reset needed
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr_q] <= wdata;
  // pointer and level registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

// File: rtl/nios_processor_adc_sequencer.sv
// nios_processor_adc_sequencer: timed ADC conversion sequencer with a sample FIFO behind an Avalon-MM slave
// Optional feature: define ADC_SEQ_IRQ_EN for the stored irq threshold and the level/flag interrupt.
module nios_processor_adc_sequencer
  import nios_processor_adc_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 1000,
  parameter int FIFO_AW     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              adc_convst,
  input  logic              adc_busy,
  input  logic [DATA_W-1:0] adc_data,
  output logic              irq
);
  logic wr, rd, wr_ctrl, wr_div, clear, tick, push, pop, fsm_busy, full, empty;
  logic [DIV_W-1:0] div_wr, div_q, div_d, cnt_q, cnt_d;
  logic enable_q, enable_d, wait_q, wait_d, ovf_q, ovf_d, ovr_q, ovr_d;
  logic [7:0] thresh;
  logic [31:0] readdata_q, readdata_d, ctrl_rd, status_rd;
  logic [DATA_W-1:0] head;
  logic [FIFO_AW:0] level;
  adc_state_e state_q, state_d;
  logic unused_wdata;

  assign wr      = chipselect & ~write_n;
  assign rd      = chipselect & ~read_n;
  assign wr_ctrl = wr && address == ADDR_CTRL;
  assign wr_div  = wr && address == ADDR_DIV;
  assign clear   = wr_ctrl & writedata[CTRL_CLR];
  assign pop     = rd && address == ADDR_DATA && !empty;
  assign div_wr  = writedata[DIV_W-1:0] < DIV_W'(DIV_MIN) ? DIV_W'(DIV_MIN) : writedata[DIV_W-1:0];
  assign readdata = readdata_q;
  assign unused_wdata = ^writedata;

  nios_processor_adc_fifo #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (clear),
    .wdata   (adc_data),
    .rdata   (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

`ifdef ADC_SEQ_IRQ_EN
  logic [7:0] thresh_q, thresh_d;
  logic irq_q, irq_d;
  // threshold is stored; irq is a registered level of the fill/sticky-flag condition
  always_comb begin
    thresh_d = wr_ctrl ? writedata[CTRL_THR_LSB +: 8] : thresh_q;
    irq_d    = (thresh_q != '0 && 32'(level) >= 32'(thresh_q)) || ovf_q || ovr_q;
  end
  // interrupt state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      thresh_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      thresh_q <= thresh_d;
      irq_q    <= irq_d;
    end
  end
  assign thresh = thresh_q;
  assign irq    = irq_q;
`else
  assign thresh = '0;
  assign irq    = 1'b0;
`endif

  // tick counter: counts down while enabled, parked at DIV-1 otherwise; a DIV write restarts it
  always_comb begin
    tick  = enable_q && cnt_q == '0;
    cnt_d = wr_div ? div_wr - DIV_W'(1) : (!enable_q || tick) ? div_q - DIV_W'(1) : cnt_q - DIV_W'(1);
  end

  // next state: CONV ignores busy on its first cycle so the ADC has time to raise it
  always_comb begin
    wait_d  = state_q == START;
    state_d = state_q == IDLE  ? (tick ? START : IDLE) :
              state_q == START ? CONV :
              state_q == CONV  ? ((wait_q || adc_busy) ? CONV : CAPT) : IDLE;
  end

  // FSM outputs
  always_comb begin
    adc_convst = state_q == START;
    push       = state_q == CAPT;
    fsm_busy   = state_q != IDLE;
  end

  // control registers, sticky flags and the registered read mux
  always_comb begin
    enable_d = wr_ctrl ? writedata[CTRL_EN] : enable_q;
    div_d    = wr_div ? div_wr : div_q;
    ovr_d    = clear ? 1'b0 : ovr_q | (tick & fsm_busy);
    ovf_d    = clear ? 1'b0 : ovf_q | (push & full & ~pop);
    ctrl_rd  = '0;
    ctrl_rd[CTRL_EN] = enable_q;
    ctrl_rd[CTRL_THR_LSB +: 8] = thresh;
    status_rd = 32'(level);
    status_rd[STAT_OVF]  = ovf_q;
    status_rd[STAT_OVR]  = ovr_q;
    status_rd[STAT_BUSY] = fsm_busy;
    readdata_d = !rd                    ? readdata_q :
                 address == ADDR_CTRL   ? ctrl_rd :
                 address == ADDR_DIV    ? 32'(div_q) :
                 address == ADDR_STATUS ? status_rd :
                 empty                  ? '0 : 32'(head);
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // register file, tick counter and read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q   <= 1'b0;
      div_q      <= DIV_W'(DEFAULT_DIV);
      cnt_q      <= DIV_W'(DEFAULT_DIV - 1);
      ovf_q      <= 1'b0;
      ovr_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      enable_q   <= enable_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      ovr_q      <= ovr_d;
      readdata_q <= readdata_d;
    end
  end
endmodule

// File: tb/tb_nios_processor_adc_sequencer.sv
// tb_nios_processor_adc_sequencer: randomized self-checking bench with an ADC model and a FIFO reference queue
module tb_nios_processor_adc_sequencer;
`ifdef ADC_SEQ_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n;
  logic [1:0] address;
  logic chipselect, write_n, read_n;
  logic [31:0] writedata, readdata;
  logic adc_convst, adc_busy, irq;
  logic [15:0] adc_data;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios_processor_adc_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .adc_convst (adc_convst),
    .adc_busy   (adc_busy),
    .adc_data   (adc_data),
    .irq        (irq)
  );

  // ADC model: busy for busy_len cycles after a convst, then presents a new sample
  int busy_len = 3;
  bit use_fixed = 1'b1;
  int rem = 0;
  int n_conv = 0;
  int conv_cyc[$];
  bit conv_long = 1'b0;
  bit last_convst = 1'b0;
  int cyc = 0;
  bit pend = 1'b0;
  int pend_age = 0;
  logic [15:0] pend_val;
  logic [15:0] exp_q[$];
  logic [31:0] exp_rd = 0;

  always @(negedge clk) begin
    if (adc_convst && last_convst) conv_long = 1'b1;
    last_convst = adc_convst;
    if (adc_convst) begin
      adc_busy = 1'b1;
      rem = busy_len;
      n_conv++;
      conv_cyc.push_back(cyc);
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        adc_busy = 1'b0;
        adc_data = use_fixed ? 16'h1234 : 16'($urandom);
        pend_val = adc_data;
        pend = 1'b1;
        pend_age = 1;
      end
    end
  end

  // reference FIFO: capture lands one cycle after busy falls; a same-cycle read pops first; clear wins over capture
  always @(posedge clk) begin
    bit clr;
    cyc++;
    clr = chipselect && !write_n && address == 2'd0 && writedata[1];
    if (chipselect && !read_n && address == 2'd3) begin
      if (exp_q.size() > 0) exp_rd = {16'h0, exp_q.pop_front()};
      else exp_rd = 32'h0;
    end
    if (clr) exp_q.delete();
    if (pend) begin
      if (pend_age > 0) pend_age--;
      else begin
        pend = 1'b0;
        if (!clr && exp_q.size() < 16) exp_q.push_back(pend_val);
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    chipselect = 1'b1;
    read_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    read_n = 1'b1;
    d = readdata;
  endtask

  task automatic wait_conv(input int target, input int budget);
    int t = 0;
    while (n_conv < target && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (n_conv < target) begin
      errors++;
      $display("FAIL wait_conv: got %0d convst pulses, expected %0d", n_conv, target);
    end
  endtask

  task automatic wait_idle();
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++;
    if (readdata !== 32'h0 || adc_convst !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%h convst=%b irq=%b expected 0 0 0", readdata, adc_convst, irq);
    end
    rd(2'd0, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected %h", d, 32'h0); end
    rd(2'd1, d); checks++;
    if (d !== 32'd1000) begin errors++; $display("FAIL reset_div: got %0d expected 1000", d); end
    rd(2'd2, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected %h", d, 32'h0); end
    rd(2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected %h", d, 32'h0); end
    repeat (50) @(negedge clk);
    checks++;
    if (n_conv !== 0) begin errors++; $display("FAIL reset_no_convst: got %0d pulses expected 0", n_conv); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    int base;
    busy_len = 3;
    use_fixed = 1'b1;
    wr(2'd1, 32'd10);
    base = n_conv;
    wr(2'd0, 32'h1);
    wait_conv(base + 4, 200);
    wr(2'd0, 32'h0);
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (conv_cyc[base+i] - conv_cyc[base+i-1] !== 10) begin
        errors++;
        $display("FAIL basic_period: got %0d cycles expected 10", conv_cyc[base+i] - conv_cyc[base+i-1]);
      end
    end
    wait_idle();
    rd(2'd2, d); checks++;
    if (d !== 32'd4) begin errors++; $display("FAIL basic_level4: got %h expected %h", d, 32'd4); end
    rd(2'd3, d); checks++;
    if (d !== 32'h1234) begin errors++; $display("FAIL basic_data: got %h expected %h", d, 32'h1234); end
    rd(2'd2, d); checks++;
    if (d !== 32'd3) begin errors++; $display("FAIL basic_level3: got %h expected %h", d, 32'd3); end
  endtask

  task automatic test_random();
    logic [31:0] d, exp_s;
    int div, busy, nc, k, per, base, lvl;
    use_fixed = 1'b0;
    for (int it = 0; it < 5; it++) begin
      div  = it == 0 ? 4 : $urandom_range(4, 24);
      busy = it == 0 ? 8 : $urandom_range(2, 12);
      nc   = it == 1 ? 17 + $urandom_range(0, 3) : $urandom_range(2, 20);
      k    = (busy + 3 + div - 1) / div;
      per  = k * div;
      wr(2'd0, 32'h2);
      wr(2'd1, div == 4 ? 32'($urandom_range(0, 4)) : 32'(div));
      rd(2'd1, d); checks++;
      if (d !== 32'(div)) begin errors++; $display("FAIL rand_div_rb: got %0d expected %0d", d, div); end
      busy_len = busy;
      base = n_conv;
      wr(2'd0, 32'h1);
      wait_conv(base + nc, (nc + 1) * per + 50);
      wr(2'd0, 32'h0);
      wait_idle();
      for (int i = 1; i < nc; i++) begin
        checks++;
        if (conv_cyc[base+i] - conv_cyc[base+i-1] !== per) begin
          errors++;
          $display("FAIL rand_period: div=%0d busy=%0d got %0d expected %0d", div, busy,
                   conv_cyc[base+i] - conv_cyc[base+i-1], per);
        end
      end
      lvl = nc > 16 ? 16 : nc;
      exp_s = 32'(lvl);
      exp_s[16] = nc > 16;
      exp_s[17] = busy + 3 > div;
      rd(2'd2, d); checks++;
      if (d !== exp_s) begin errors++; $display("FAIL rand_status: div=%0d busy=%0d n=%0d got %h expected %h", div, busy, nc, d, exp_s); end
      for (int j = 0; j < (lvl < 3 ? lvl : 3); j++) begin
        rd(2'd3, d); checks++;
        if (d !== exp_rd) begin errors++; $display("FAIL rand_data: got %h expected %h", d, exp_rd); end
      end
      wr(2'd0, 32'h2);
      rd(2'd0, d); checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL clear_ctrl: got %h expected %h", d, 32'h0); end
      rd(2'd2, d); checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL clear_status: got %h expected %h", d, 32'h0); end
      rd(2'd3, d); checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL empty_data: got %h expected %h", d, 32'h0); end
    end
    checks++;
    if (conv_long) begin errors++; $display("FAIL convst_width: got multi-cycle pulse expected 1 cycle"); end
  endtask

  task automatic test_full_pop();
    logic [31:0] d;
    logic [15:0] old;
    int t;
    use_fixed = 1'b0;
    busy_len = 3;
    wr(2'd0, 32'h2);
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    t = 0;
    while (!(exp_q.size() == 16 && !pend && adc_busy) && t < 400) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (t >= 400) begin errors++; $display("FAIL full_wait: got level %0d expected 16 with busy", exp_q.size()); end
    old = exp_q[0];
    t = 0;
    while (adc_busy && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    @(negedge clk);
    rd(2'd3, d);
    wr(2'd0, 32'h0);
    checks++;
    if (d !== {16'h0, old}) begin errors++; $display("FAIL full_pop_data: got %h expected %h", d, {16'h0, old}); end
    wait_idle();
    rd(2'd2, d); checks++;
    if (d !== 32'h10) begin errors++; $display("FAIL full_pop_status: got %h expected %h", d, 32'h10); end
    rd(2'd3, d); checks++;
    if (d !== exp_rd) begin errors++; $display("FAIL full_pop_next: got %h expected %h", d, exp_rd); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    int t;
    busy_len = 3;
    wr(2'd0, 32'h2);
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h401);
    rd(2'd0, d); checks++;
    if (d !== (IRQ_ON ? 32'h401 : 32'h1)) begin errors++; $display("FAIL irq_ctrl_rb: got %h expected %h", d, IRQ_ON ? 32'h401 : 32'h1); end
    t = 0;
    while (exp_q.size() < 3 && t < 300) begin @(negedge clk); #1; t++; end
    checks++;
    if (exp_q.size() < 3) begin errors++; $display("FAIL irq_wait3: got level %0d expected 3", exp_q.size()); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_below: got %b expected 0", irq); end
    t = 0;
    while (exp_q.size() < 4 && t < 100) begin @(negedge clk); #1; t++; end
    wr(2'd0, 32'h400);
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== IRQ_ON) begin errors++; $display("FAIL irq_at_thresh: got %b expected %b", irq, IRQ_ON); end
    rd(2'd3, d); checks++;
    if (d !== exp_rd) begin errors++; $display("FAIL irq_data: got %h expected %h", d, exp_rd); end
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b expected 0", irq); end
  endtask

  initial begin
    reset_n = 1'b0;
    address = 2'd0;
    chipselect = 1'b0;
    write_n = 1'b1;
    read_n = 1'b1;
    writedata = 32'h0;
    adc_busy = 1'b0;
    adc_data = 16'h0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_random();
    test_full_pop();
    test_irq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
